comm_send_frame: RTL and testbench

Parametrised serial frame transmitter; successor to the fixed 8-bit `communication_send`. Accepts parallel words through a ready/enable handshake, double-buffers them, and serialises each as start / data / optional parity / stop bits on `sd`. It also drives a bit-rate clock `freq` and a session-valid `rec_en` toward the receive side. It sits between the host-side data source and the link to `communication_receive`.

---
 rtl/comm_pkg.sv | 16 +
 rtl/comm_bit_timer.sv | 34 +++
 rtl/comm_send_frame.sv | 126 ++++++++++++
 tb/tb_comm_send_frame.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comm_pkg.sv
// Shared definitions for the serial frame transmitter: parity modes and FSM states.
package comm_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/comm_bit_timer.sv
// Bit-period divider: flags the last cycle of each bit and shapes the bit clock,
// which is high for the first half of every bit and low while idle.
module comm_bit_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic bit_tick,
  output logic freq
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HALF  = CLK_DIV / 2;

  logic [CNT_W-1:0] cnt;
  logic             first_half;

  assign bit_tick   = run && (cnt == CNT_W'(CLK_DIV - 1));
  assign first_half = (cnt < CNT_W'(HALF));

  // freq is registered so it lines up with the registered serial output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      freq <= 1'b0;
    end else begin
      if (!run || bit_tick) cnt <= '0;
      else                  cnt <= cnt + CNT_W'(1);
      freq <= run && first_half;
    end
  end

endmodule

// File: rtl/comm_send_frame.sv
// Parametrised serial frame transmitter: double-buffered word input, start/data/
// parity/stop serialisation, bit clock and session-valid toward the receiver.
module comm_send_frame
  import comm_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int CLK_DIV   = 4,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int MSB_FIRST = 1
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic [DATA_W-1:0] send_data,
  input  logic              send_en,
  output logic              send_ready,
  input  logic              finish_send,
  output logic              sd,
  output logic              freq,
  output logic              rec_en,
  output logic              busy,
  output logic              done,
  output logic              overrun,
  output logic [2:0]        state
);

  localparam int BIT_W = $clog2(DATA_W + 1);

  tx_state_t         st;
  logic [DATA_W-1:0] hold;
  logic [DATA_W-1:0] shift;
  logic              hold_full;
  logic              par_bit;
  logic [BIT_W-1:0]  bit_cnt;
  logic              run;
  logic              bit_tick;
  logic              stop_end;
  logic              load_shift;
  logic              accept;
  logic              tx_bit;

  // Handshake: a word is taken on any edge where send_en && send_ready; send_ready
  // is simply "holding buffer empty", so the source may present data at will.
  assign send_ready = !hold_full;
  assign accept     = send_en && !hold_full;
  assign run        = (st != ST_IDLE);
  assign stop_end   = (st == ST_STOP) && bit_tick && (bit_cnt == BIT_W'(STOP_BITS - 1));
  assign load_shift = hold_full && ((st == ST_IDLE) || stop_end);
  assign tx_bit     = (MSB_FIRST != 0) ? shift[DATA_W-1] : shift[0];
  assign state      = st;

  comm_bit_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk      (clk1),
    .rst      (rst),
    .run      (run),
    .bit_tick (bit_tick),
    .freq     (freq)
  );

  // Wire-facing outputs are registered from the FSM, so they trail it by one cycle.
  always_ff @(posedge clk1 or negedge rst) begin
    if (!rst) begin
      st        <= ST_IDLE;
      hold      <= '0;
      shift     <= '0;
      hold_full <= 1'b0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      sd        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      rec_en    <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (accept) hold <= send_data;
      if (accept)          hold_full <= 1'b1;
      else if (load_shift) hold_full <= 1'b0;
      if (send_en && hold_full) overrun <= 1'b1;

      busy <= run;
      done <= stop_end;
      if (run)              rec_en <= 1'b1;
      else if (finish_send) rec_en <= 1'b0;

      unique case (st)
        ST_START:  sd <= 1'b0;
        ST_DATA:   sd <= tx_bit;
        ST_PARITY: sd <= par_bit;
        default:   sd <= 1'b1;
      endcase

      if (load_shift) begin
        shift   <= hold;
        par_bit <= (^hold) ^ (PARITY == PAR_ODD);
        bit_cnt <= '0;
        st      <= ST_START;
      end else if (bit_tick) begin
        unique case (st)
          ST_START: begin
            bit_cnt <= '0;
            st      <= ST_DATA;
          end
          ST_DATA: begin
            shift <= (MSB_FIRST != 0) ? (shift << 1) : (shift >> 1);
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              bit_cnt <= '0;
              st      <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
          ST_PARITY: begin
            bit_cnt <= '0;
            st      <= ST_STOP;
          end
          ST_STOP: begin
            if (bit_cnt == BIT_W'(STOP_BITS - 1)) st <= ST_IDLE;
            else                                  bit_cnt <= bit_cnt + BIT_W'(1);
          end
          default: st <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_comm_send_frame.sv
// Bench for comm_send_frame: per-cycle expected-waveform queue built from frame rules,
// plus a directed odd-parity LSB-first instance.
module tb_comm_send_frame;

  localparam int CD = 4;

  typedef struct packed {
    logic sd;
    logic freq;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  logic       clk1 = 1'b0;
  logic       rst;
  logic [7:0] send_data;
  logic       send_en;
  logic       finish_send;
  logic       send_ready, sd, freq, rec_en, busy, done, overrun;
  logic [2:0] state;

  logic [7:0] send_data2;
  logic       send_en2;
  logic       finish2;
  logic       send_ready2, sd2, freq2, rec_en2, busy2, done2, overrun2;
  logic [2:0] state2;

  exp_t exp_q[$];
  logic rec_exp;
  logic ovr_exp;
  int   pass_cnt  = 0;
  int   fail_cnt  = 0;
  int   total_cnt = 0;
  bit   dummy;

  always #5 clk1 = ~clk1;

  comm_send_frame u_dut (
    .clk1(clk1), .rst(rst), .send_data(send_data), .send_en(send_en),
    .send_ready(send_ready), .finish_send(finish_send), .sd(sd), .freq(freq),
    .rec_en(rec_en), .busy(busy), .done(done), .overrun(overrun), .state(state)
  );

  comm_send_frame #(.PARITY(2), .MSB_FIRST(0)) u_dut2 (
    .clk1(clk1), .rst(rst), .send_data(send_data2), .send_en(send_en2),
    .send_ready(send_ready2), .finish_send(finish2), .sd(sd2), .freq(freq2),
    .rec_en(rec_en2), .busy(busy2), .done(done2), .overrun(overrun2), .state(state2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Bits of one frame in wire order.
  function automatic int frame_bits(input logic [31:0] w, input int dw, input int par,
                                    input int stops, input bit msb, output logic [63:0] bits);
    int n;
    int ones;
    logic b;
    bits = '1;
    n = 0;
    ones = 0;
    bits[n] = 1'b0;
    n++;
    for (int j = 0; j < dw; j++) begin
      b = msb ? w[dw-1-j] : w[j];
      bits[n] = b;
      if (b) ones++;
      n++;
    end
    if (par != 0) begin
      bits[n] = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
      n++;
    end
    for (int s = 0; s < stops; s++) begin
      bits[n] = 1'b1;
      n++;
    end
    return n;
  endfunction

  task automatic push_idle(input logic rdy);
    exp_t e;
    e.sd = 1'b1; e.freq = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ready = rdy;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [7:0] w);
    logic [63:0] bits;
    int n;
    exp_t e;
    n = frame_bits({24'd0, w}, 8, 0, 1, 1'b1, bits);
    for (int i = 0; i < n; i++) begin
      for (int c = 0; c < CD; c++) begin
        e.sd    = bits[i];
        e.freq  = (c < CD / 2);
        e.busy  = 1'b1;
        e.done  = (i == n - 1) && (c == CD - 1);
        e.ready = 1'b1;
        exp_q.push_back(e);
      end
    end
  endtask

  // One clock: check the current cycle against the model, then drive the next edge.
  task automatic step(input bit want, input bit force_en, input logic [7:0] data,
                      input logic fin, output bit accepted);
    exp_t e;
    bit allowed;
    @(negedge clk1);
    if (exp_q.size() > 0) e = exp_q.pop_front();
    else begin
      e.sd = 1'b1; e.freq = 1'b0; e.busy = 1'b0; e.done = 1'b0; e.ready = 1'b1;
    end
    rec_exp = e.busy ? 1'b1 : (finish_send ? 1'b0 : rec_exp);
    chk("sd", sd, e.sd);
    chk("freq", freq, e.freq);
    chk("busy", busy, e.busy);
    chk("done", done, e.done);
    chk("send_ready", send_ready, e.ready);
    chk("rec_en", rec_en, rec_exp);
    chk("overrun", overrun, ovr_exp);
    allowed  = e.ready && (exp_q.size() == 0 || exp_q.size() >= 2);
    accepted = 1'b0;
    send_en  = 1'b0;
    if (want && allowed) begin
      send_en  = 1'b1;
      accepted = 1'b1;
    end else if (force_en && !e.ready) begin
      send_en = 1'b1;
    end
    send_data   = data;
    finish_send = fin;
    if (send_en && !e.ready) ovr_exp = 1'b1;
    if (accepted) begin
      if (exp_q.size() == 0) begin
        push_idle(1'b0);
        push_idle(1'b1);
      end else begin
        for (int i = 0; i < exp_q.size() - 1; i++) exp_q[i].ready = 1'b0;
      end
      push_frame(data);
    end
  endtask

  task automatic send_word(input logic [7:0] w, input logic fin);
    bit acc;
    int tries;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 200) begin
      step(1'b1, 1'b0, w, fin, acc);
      tries++;
    end
    chk("accept_bound", acc, 1'b1);
  endtask

  task automatic idle(input int n, input logic fin);
    bit acc;
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, fin, acc);
  endtask

  task automatic drain(input logic fin);
    bit acc;
    while (exp_q.size() > 0) step(1'b0, 1'b0, 8'h00, fin, acc);
    step(1'b0, 1'b0, 8'h00, fin, acc);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sd"}, sd, 1'b1);
    chk({tag, "_freq"}, freq, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_ready"}, send_ready, 1'b1);
    chk({tag, "_rec_en"}, rec_en, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
  endtask

  initial begin
    logic [63:0] b2;
    int n2;
    int s;
    logic [7:0] w;
    logic fr;

    rst = 1'b0; send_data = '0; send_en = 1'b0; finish_send = 1'b0;
    send_data2 = '0; send_en2 = 1'b0; finish2 = 1'b0;
    rec_exp = 1'b0; ovr_exp = 1'b0;
    repeat (3) @(negedge clk1);
    chk_reset_vals("reset");
    chk("reset_sd2", sd2, 1'b1);
    rst = 1'b1;
    idle(3, 1'b0);

    // single word, default format
    send_word(8'hAE, 1'b0);
    drain(1'b0);

    // back-to-back words
    send_word(8'h55, 1'b0);
    send_word(8'hA3, 1'b0);
    drain(1'b0);

    // rec_en held across an idle gap, then session ended mid-frame
    idle(6, 1'b0);
    send_word(8'h3C, 1'b0);
    idle(15, 1'b0);
    drain(1'b1);
    idle(3, 1'b1);
    idle(2, 1'b0);

    // randomised words, gaps and session ends
    for (int k = 0; k < 24; k++) begin
      w  = 8'($urandom);
      fr = 1'($urandom_range(0, 1));
      send_word(w, fr);
      idle($urandom_range(0, 3), fr);
    end
    drain(1'b0);
    idle(2, 1'b0);

    // odd parity, LSB first instance
    n2 = frame_bits(32'hAE, 8, 2, 1, 1'b0, b2);
    @(negedge clk1);
    send_data2 = 8'hAE; send_en2 = 1'b1;
    @(negedge clk1);
    send_en2 = 1'b0;
    s = 0;
    while (busy2 !== 1'b1 && s < 10) begin
      @(negedge clk1);
      s++;
    end
    chk("dut2_start", busy2, 1'b1);
    chk("dut2_start_sd", sd2, 1'b0);
    @(negedge clk1);
    for (int i = 0; i < n2; i++) begin
      chk($sformatf("dut2_bit%0d", i), sd2, b2[i]);
      if (i < n2 - 1) repeat (CD) @(negedge clk1);
    end
    repeat (2) @(negedge clk1);
    chk("dut2_done", done2, 1'b1);
    chk("dut2_busy_last", busy2, 1'b1);
    @(negedge clk1);
    chk("dut2_busy_end", busy2, 1'b0);
    chk("dut2_sd_end", sd2, 1'b1);

    // overrun: request while the buffer is full
    send_word(8'h96, 1'b0);
    step(1'b0, 1'b1, 8'hFF, 1'b0, dummy);
    step(1'b0, 1'b1, 8'hFF, 1'b0, dummy);
    step(1'b0, 1'b1, 8'hFF, 1'b0, dummy);
    drain(1'b0);
    send_word(8'h5A, 1'b0);
    drain(1'b0);

    // asynchronous reset in the middle of the data bits
    send_word(8'h3C, 1'b0);
    idle(12, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    chk_reset_vals("midreset");
    exp_q.delete();
    rec_exp = 1'b0;
    ovr_exp = 1'b0;
    send_en = 1'b0;
    @(negedge clk1);
    @(negedge clk1);
    rst = 1'b1;
    send_word(8'h0F, 1'b0);
    drain(1'b0);
    idle(2, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
